piso_shift_register: RTL and testbench

- Parallel-in, serial-out register: accepts an n-bit word over a valid/ready handshake and shifts it out one bit per clock.
- It is the read-out end of the parallel register path. It converts a captured parallel word into a bit stream for serial links and for the serial-in shift registers elsewhere in the codebase.
- Supports back-to-back words with no idle bubble.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_shift_register_if.sv | 22 ++
 rtl/piso_bit_counter.sv | 31 +++
 rtl/piso_shift_register.sv | 113 +++++++++++
 tb/tb_piso_shift_register.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the PISO shift register.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
`timescale 1ns/1ps
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits emitted per accepted word: the data bits, plus parity when enabled.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter must be able to hold FRAME-1; sized for FRAME to leave headroom.
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Load handshake and serial output bundle of the PISO shift register.
`timescale 1ns/1ps
interface piso_shift_register_if #(
  parameter int N = 4
);
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] din;
  logic         sout;
  logic         sout_valid;
  logic         last;

  modport slave (
    input  load_valid, din,
    output load_ready, sout, sout_valid, last
  );

  modport master (
    output load_valid, din,
    input  load_ready, sout, sout_valid, last
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clears on accept or frame end, counts while shifting,
// and flags the final bit of the frame through o_tc.
`timescale 1ns/1ps
module piso_bit_counter #(
  parameter int FRAME = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CW'(FRAME - 1));

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out register with valid/ready load and gapless reload.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
`timescale 1ns/1ps
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  piso_shift_register_if.slave  bus
);

  localparam int FRAME = frame_len(n);
  localparam int CW    = cnt_width(FRAME);

  state_e         r_state;
  state_e         w_next_state;
  logic [n-1:0]   r_sreg;
  logic           w_accept;
  logic           w_tc;
  logic           w_shifting;
  logic           w_load_ready;
  logic           w_sout_valid;
  logic           w_last;
  logic           w_sout;
  logic           w_data_bit;
  logic           w_cnt_clear;

`ifdef PISO_PARITY_EN
  logic           r_parity;
`endif

  assign w_shifting  = (r_state == SHIFT);
  assign w_accept    = bus.load_valid && w_load_ready;
  assign w_data_bit  = MSB_FIRST ? r_sreg[n-1] : r_sreg[0];
  // Restart the count on every accept, and park it at zero when a frame ends.
  assign w_cnt_clear = w_accept || (w_shifting && w_tc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_accept)           w_next_state = SHIFT;
      SHIFT: if (w_tc && !w_accept)  w_next_state = IDLE;
      default:                       w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_sout_valid = w_shifting;
    w_last       = w_shifting && w_tc;
    // Gated by rst so nothing is accepted while reset is held.
    w_load_ready = !rst && (!w_shifting || w_last);
    w_sout       = 1'b0;
    if (w_sout_valid) begin
`ifdef PISO_PARITY_EN
      w_sout = w_tc ? r_parity : w_data_bit;
`else
      w_sout = w_data_bit;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (w_accept) begin
      r_sreg <= bus.din;
    end else if (w_shifting) begin
      r_sreg <= MSB_FIRST ? {r_sreg[n-2:0], 1'b0} : {1'b0, r_sreg[n-1:1]};
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is latched with the word, because the shifter empties before the
  // parity bit goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^bus.din;
    end
  end
`endif

  piso_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_en    (w_shifting),
    .o_tc    (w_tc)
  );

  assign bus.load_ready = w_load_ready;
  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_sout_valid;
  assign bus.last       = w_last;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: an MSB-first and an LSB-first
// instance; expectations follow PISO_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_piso_shift_register;

  localparam int N = 4;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
  // Serial streams, first bit out at index FRAME-1 (or 2*FRAME-1).
  localparam logic [4:0] E_1011     = 5'b10111;
  localparam logic [4:0] E_0111     = 5'b01111;
  localparam logic [4:0] E_0101     = 5'b01010;
  localparam logic [4:0] E_0011     = 5'b00110;
  localparam logic [4:0] E_LSB_0001 = 5'b10001;
  localparam logic [9:0] E_B2B      = 10'b1010001010;
`else
  localparam int FRAME = 4;
  localparam logic [4:0] E_1011     = 5'b01011;
  localparam logic [4:0] E_0111     = 5'b00111;
  localparam logic [4:0] E_0101     = 5'b00101;
  localparam logic [4:0] E_0011     = 5'b00011;
  localparam logic [4:0] E_LSB_0001 = 5'b01000;
  localparam logic [9:0] E_B2B      = 10'b0010100101;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_shift_register_if #(.N(N)) bus_m ();
  piso_shift_register_if #(.N(N)) bus_l ();

  piso_shift_register #(.n(N), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  piso_shift_register #(.n(N), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word through the MSB-first instance, with din scrambled after accept.
  task automatic send_m(input string tag, input logic [3:0] word, input logic [4:0] exp_bits);
    check($sformatf("%s_ready_pre", tag), bus_m.load_ready, 1'b1);
    bus_m.load_valid = 1'b1;
    bus_m.din        = word;
    step();
    bus_m.load_valid = 1'b0;
    bus_m.din        = ~word;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("%s_sout%0d", tag, i),  bus_m.sout,       exp_bits[FRAME-1-i]);
      check($sformatf("%s_valid%0d", tag, i), bus_m.sout_valid, 1'b1);
      check($sformatf("%s_last%0d", tag, i),  bus_m.last,       (i == FRAME-1));
      check($sformatf("%s_ready%0d", tag, i), bus_m.load_ready, (i == FRAME-1));
      step();
    end
    check($sformatf("%s_idle_valid", tag), bus_m.sout_valid, 1'b0);
    check($sformatf("%s_idle_sout", tag),  bus_m.sout,       1'b0);
    check($sformatf("%s_idle_ready", tag), bus_m.load_ready, 1'b1);
  endtask

  initial begin
    rst              = 1'b1;
    bus_m.load_valid = 1'b0;
    bus_m.din        = '0;
    bus_l.load_valid = 1'b0;
    bus_l.din        = '0;

    #12;
    check("rst_m_valid", bus_m.sout_valid, 1'b0);
    check("rst_m_ready", bus_m.load_ready, 1'b0);
    check("rst_m_last",  bus_m.last,       1'b0);
    check("rst_m_sout",  bus_m.sout,       1'b0);
    check("rst_l_ready", bus_l.load_ready, 1'b0);

    step();
    rst = 1'b0;
    #1;
    check("rel_m_ready", bus_m.load_ready, 1'b1);
    check("rel_l_ready", bus_l.load_ready, 1'b1);
    step();

    send_m("w1011", 4'b1011, E_1011);
    send_m("w0111", 4'b0111, E_0111);
    send_m("w0101", 4'b0101, E_0101);

    // Back-to-back A then 5 with load_valid held across the boundary.
    bus_m.load_valid = 1'b1;
    bus_m.din        = 4'hA;
    step();
    for (int i = 0; i < 2*FRAME; i++) begin
      check($sformatf("b2b_sout%0d", i),  bus_m.sout,       E_B2B[2*FRAME-1-i]);
      check($sformatf("b2b_valid%0d", i), bus_m.sout_valid, 1'b1);
      check($sformatf("b2b_last%0d", i),  bus_m.last,       (i == FRAME-1) || (i == 2*FRAME-1));
      if (i == 0)     bus_m.din        = 4'h5;
      if (i == FRAME) bus_m.load_valid = 1'b0;
      step();
    end
    check("b2b_idle_valid", bus_m.sout_valid, 1'b0);

    // LSB-first instance, din changed to F mid-frame.
    bus_l.load_valid = 1'b1;
    bus_l.din        = 4'b0001;
    step();
    bus_l.load_valid = 1'b0;
    bus_l.din        = 4'hF;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("lsb_sout%0d", i), bus_l.sout, E_LSB_0001[FRAME-1-i]);
      check($sformatf("lsb_last%0d", i), bus_l.last, (i == FRAME-1));
      step();
    end
    check("lsb_idle_valid", bus_l.sout_valid, 1'b0);

    // Reset asserted between edges, two bits into 4'hC.
    bus_m.load_valid = 1'b1;
    bus_m.din        = 4'hC;
    step();
    bus_m.load_valid = 1'b0;
    check("abort_sout0", bus_m.sout, 1'b1);
    step();
    check("abort_sout1", bus_m.sout, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", bus_m.sout_valid, 1'b0);
    check("abort_sout",  bus_m.sout,       1'b0);
    check("abort_last",  bus_m.last,       1'b0);
    check("abort_ready", bus_m.load_ready, 1'b0);
    bus_m.load_valid = 1'b1;
    bus_m.din        = 4'hF;
    step();
    step();
    check("inrst_valid", bus_m.sout_valid, 1'b0);
    check("inrst_ready", bus_m.load_ready, 1'b0);
    bus_m.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("postrst_valid", bus_m.sout_valid, 1'b0);
    step();
    send_m("w0011", 4'h3, E_0011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
